// File: rtl/rs_age_sel.sv
// rs_age_sel: reservation station with multi-CDB wakeup,
// oldest-first select by ROB age and selective squash.
module rs_age_sel #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int PREG_W  = 7,
  parameter int ROB_W   = 5,
  parameter int IMM_W   = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        di_en,
  input  logic [PREG_W-1:0]           di_ps1,
  input  logic [PREG_W-1:0]           di_ps2,
  input  logic [PREG_W-1:0]           di_pd,
  input  logic [IMM_W-1:0]            di_imm,
  input  logic [ROB_W-1:0]            di_rob,
  input  logic                        di_ps1_rdy,
  input  logic                        di_ps2_rdy,
  output logic                        di_accept,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_tag,
  input  logic                        fu_ready,
  input  logic [ROB_W-1:0]            rob_head,
  input  logic                        mispredict,
  input  logic [ROB_W-1:0]            mispredict_rob,
  output logic                        issue_valid,
  output logic [PREG_W-1:0]           issue_ps1,
  output logic [PREG_W-1:0]           issue_ps2,
  output logic [PREG_W-1:0]           issue_pd,
  output logic [IMM_W-1:0]            issue_imm,
  output logic [ROB_W-1:0]            issue_rob,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [PREG_W-1:0] ps1;
    logic              r1;
    logic [PREG_W-1:0] ps2;
    logic              r2;
    logic [PREG_W-1:0] pd;
    logic [IMM_W-1:0]  imm;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t               ent_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;

  logic [DEPTH-1:0]   w1;
  logic [DEPTH-1:0]   w2;
  logic               d1;
  logic               d2;
  logic [ROB_W-1:0]   age [DEPTH];
  logic [ROB_W-1:0]   m_age;
  logic [DEPTH-1:0]   kill;
  logic [CNT_W-1:0]   n_kill;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [ROB_W-1:0]   sel_age;
  logic               do_issue;
  logic               do_disp;
  logic [CNT_W-1:0]   count_next;

  assign di_accept = di_en & ~full & ~mispredict;
  assign do_disp   = di_accept;
  assign do_issue  = fu_ready & ~mispredict & sel_found;
  assign m_age     = mispredict_rob - rob_head;

  // tag match of stored and incoming sources against every CDB port
  always_comb begin
    w1 = '0;
    w2 = '0;
    d1 = di_ps1_rdy;
    d2 = di_ps2_rdy;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid[k] &&
            cdb_tag[k*PREG_W +: PREG_W] == ent_q[i].ps1)
          w1[i] = 1'b1;
        if (cdb_valid[k] &&
            cdb_tag[k*PREG_W +: PREG_W] == ent_q[i].ps2)
          w2[i] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] &&
          cdb_tag[k*PREG_W +: PREG_W] == di_ps1)
        d1 = 1'b1;
      if (cdb_valid[k] &&
          cdb_tag[k*PREG_W +: PREG_W] == di_ps2)
        d2 = 1'b1;
    end
  end

  // per-entry age relative to head, squash mask and kill count
  always_comb begin
    kill   = '0;
    n_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]  = ent_q[i].rob - rob_head;
      kill[i] = mispredict & vld_q[i] & (age[i] > m_age);
      n_kill  = n_kill + CNT_W'(kill[i]);
    end
  end

  // lowest free slot and oldest ready entry; lower index wins ties
  always_comb begin
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i])
        free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ent_q[i].r1 && ent_q[i].r2 &&
          (!sel_found || age[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  assign count_next = count + CNT_W'(do_disp)
                    - CNT_W'(do_issue) - n_kill;

  // entry storage: wakeup, issue/squash invalidation, dispatch write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && w1[i])
          ent_q[i].r1 <= 1'b1;
        if (vld_q[i] && w2[i])
          ent_q[i].r2 <= 1'b1;
        if (kill[i] || (do_issue && sel_idx == IDX_W'(i)))
          vld_q[i] <= 1'b0;
      end
      if (do_disp) begin
        vld_q[free_idx] <= 1'b1;
        ent_q[free_idx] <= '{
          ps1: di_ps1, r1: d1,
          ps2: di_ps2, r2: d2,
          pd:  di_pd,  imm: di_imm,
          rob: di_rob
        };
      end
    end
  end

  // issue register: pulse valid, hold fields between issues
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_ps1   <= '0;
      issue_ps2   <= '0;
      issue_pd    <= '0;
      issue_imm   <= '0;
      issue_rob   <= '0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_ps1 <= ent_q[sel_idx].ps1;
        issue_ps2 <= ent_q[sel_idx].ps2;
        issue_pd  <= ent_q[sel_idx].pd;
        issue_imm <= ent_q[sel_idx].imm;
        issue_rob <= ent_q[sel_idx].rob;
      end
    end
  end

  // occupancy counter and full flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_rs_age_sel.sv
// tb_rs_age_sel: directed plan plus random traffic,
// checked against a queue-based model of the station.
module tb_rs_age_sel;

  localparam int DEPTH = 8;
  localparam int NC    = 2;
  localparam int PW    = 7;
  localparam int RW    = 5;
  localparam int IW    = 33;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              di_en;
  logic [PW-1:0]     di_ps1, di_ps2, di_pd;
  logic [IW-1:0]     di_imm;
  logic [RW-1:0]     di_rob;
  logic              di_ps1_rdy, di_ps2_rdy;
  logic              di_accept;
  logic [NC-1:0]     cdb_valid;
  logic [NC*PW-1:0]  cdb_tag;
  logic              fu_ready;
  logic [RW-1:0]     rob_head;
  logic              mispredict;
  logic [RW-1:0]     mispredict_rob;
  logic              issue_valid;
  logic [PW-1:0]     issue_ps1, issue_ps2, issue_pd;
  logic [IW-1:0]     issue_imm;
  logic [RW-1:0]     issue_rob;
  logic              full;
  logic [3:0]        count;

  always #5 clk = ~clk;

  rs_age_sel dut (
    .clk(clk), .reset(reset),
    .di_en(di_en), .di_ps1(di_ps1), .di_ps2(di_ps2),
    .di_pd(di_pd), .di_imm(di_imm), .di_rob(di_rob),
    .di_ps1_rdy(di_ps1_rdy), .di_ps2_rdy(di_ps2_rdy),
    .di_accept(di_accept),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .fu_ready(fu_ready), .rob_head(rob_head),
    .mispredict(mispredict),
    .mispredict_rob(mispredict_rob),
    .issue_valid(issue_valid), .issue_ps1(issue_ps1),
    .issue_ps2(issue_ps2), .issue_pd(issue_pd),
    .issue_imm(issue_imm), .issue_rob(issue_rob),
    .full(full), .count(count)
  );

  typedef struct {
    int     rob;
    int     ps1;
    bit     r1;
    int     ps2;
    bit     r2;
    int     pd;
    longint imm;
    int     seq;
  } ment_t;

  ment_t  mq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     tail = 0;
  bit     exp_acc, exp_iv;
  int     e_ps1 = 0, e_ps2 = 0, e_pd = 0, e_rob = 0;
  longint e_imm = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int age(input int x, input int h);
    return (x - h + 32) % 32;
  endfunction

  function automatic bit hit(input int t);
    for (int k = 0; k < NC; k++)
      if (cdb_valid[k] && int'(cdb_tag[k*PW +: PW]) == t)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    di_en = 0; di_ps1 = 0; di_ps2 = 0; di_pd = 0;
    di_imm = 0; di_rob = 0;
    di_ps1_rdy = 0; di_ps2_rdy = 0;
    cdb_valid = 0; cdb_tag = 0;
    fu_ready = 0; mispredict = 0; mispredict_rob = 0;
  endtask

  task automatic disp(input int p1, input bit r1,
                      input int p2, input bit r2,
                      input int pd, input longint imm,
                      input int rob);
    logic [63:0] iv;
    iv = imm;
    di_en = 1;
    di_ps1 = PW'(p1); di_ps1_rdy = r1;
    di_ps2 = PW'(p2); di_ps2_rdy = r2;
    di_pd = PW'(pd);
    di_imm = iv[IW-1:0];
    di_rob = RW'(rob);
  endtask

  task automatic model_step();
    int best, ba, ma, h;
    ment_t e;
    h = int'(rob_head);
    exp_acc = di_en && mq.size() < DEPTH && !mispredict;
    exp_iv = 0;
    best = -1;
    ba = 0;
    if (fu_ready && !mispredict)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].r1 && mq[i].r2 &&
            (best < 0 || age(mq[i].rob, h) < ba)) begin
          best = i;
          ba = age(mq[i].rob, h);
        end
    if (best >= 0) begin
      exp_iv = 1;
      e_ps1 = mq[best].ps1; e_ps2 = mq[best].ps2;
      e_pd = mq[best].pd; e_rob = mq[best].rob;
      e_imm = mq[best].imm;
      mq.delete(best);
    end
    if (mispredict) begin
      ma = age(int'(mispredict_rob), h);
      for (int i = mq.size() - 1; i >= 0; i--)
        if (age(mq[i].rob, h) > ma)
          mq.delete(i);
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (hit(mq[i].ps1)) mq[i].r1 = 1;
      if (hit(mq[i].ps2)) mq[i].r2 = 1;
    end
    if (exp_acc) begin
      e.rob = int'(di_rob);
      e.ps1 = int'(di_ps1);
      e.r1  = di_ps1_rdy || hit(int'(di_ps1));
      e.ps2 = int'(di_ps2);
      e.r2  = di_ps2_rdy || hit(int'(di_ps2));
      e.pd  = int'(di_pd);
      e.imm = longint'(di_imm);
      e.seq = tail;
      mq.push_back(e);
      tail++;
    end
  endtask

  task automatic check_outs();
    check("issue_valid", 64'(issue_valid), 64'(exp_iv));
    check("issue_ps1", 64'(issue_ps1), 64'(e_ps1));
    check("issue_ps2", 64'(issue_ps2), 64'(e_ps2));
    check("issue_pd", 64'(issue_pd), 64'(e_pd));
    check("issue_imm", 64'(issue_imm), 64'(e_imm));
    check("issue_rob", 64'(issue_rob), 64'(e_rob));
    check("count", 64'(count), 64'(mq.size()));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
  endtask

  task automatic cycle();
    #1;
    model_step();
    check("di_accept", 64'(di_accept), 64'(exp_acc));
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && mq.size() > 0; n++) begin
      idle();
      fu_ready = 1;
      cdb_valid = 2'b11;
      cdb_tag = {PW'(mq[0].ps2), PW'(mq[0].ps1)};
      cycle();
    end
  endtask

  initial begin
    int minseq;
    idle();
    rob_head = 0;
    reset = 0;
    #12;
    check_outs();
    @(negedge clk);
    reset = 1;

    // plan 1: oldest ready first, wakeup latency
    idle(); disp(1, 1, 2, 1, 20, 100, 3); fu_ready = 1;
    cycle();
    idle(); disp(4, 1, 13, 0, 21, 101, 5); fu_ready = 1;
    cycle();
    check("t1_first_rob", 64'(issue_rob), 64'd3);
    idle(); fu_ready = 1;
    cdb_valid = 2'b10; cdb_tag = {PW'(13), PW'(0)};
    cycle();
    check("t1_no_early", 64'(issue_valid), 64'd0);
    idle(); fu_ready = 1;
    cycle();
    check("t1_second_rob", 64'(issue_rob), 64'd5);

    // plan 2: same-cycle bypass at dispatch
    idle(); disp(30, 0, 31, 1, 22, 102, 6);
    cdb_valid = 2'b01; cdb_tag = {PW'(0), PW'(30)};
    fu_ready = 1;
    cycle();
    idle(); fu_ready = 1;
    cycle();
    check("t2_iv", 64'(issue_valid), 64'd1);
    check("t2_rob", 64'(issue_rob), 64'd6);

    // plan 3: age wraps around rob_head
    rob_head = 30;
    idle(); disp(5, 1, 6, 1, 23, 103, 2); cycle();
    idle(); disp(7, 1, 8, 1, 24, 104, 31); cycle();
    idle(); fu_ready = 1; cycle();
    check("t3_first", 64'(issue_rob), 64'd31);
    idle(); fu_ready = 1; cycle();
    check("t3_second", 64'(issue_rob), 64'd2);

    // plan 4: fill, reject when full, drain
    rob_head = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); disp(10 + i, 1, 40 + i, 1, 50 + i, 200 + i, i);
      cycle();
    end
    check("t4_full", 64'(full), 64'd1);
    check("t4_count", 64'(count), 64'd8);
    idle(); disp(99, 1, 98, 1, 97, 96, 9);
    cycle();
    idle(); fu_ready = 1; cycle();
    check("t4_notfull", 64'(full), 64'd0);
    check("t4_ps1", 64'(issue_ps1), 64'd10);
    drain();

    // plan 5: squash younger than branch
    rob_head = 0;
    for (int i = 1; i <= 4; i++) begin
      idle(); disp(60, 1, 70 + i, 0, 80 + i, 300 + i, i);
      cycle();
    end
    idle(); disp(61, 1, 62, 1, 63, 64, 9);
    fu_ready = 1; mispredict = 1; mispredict_rob = 2;
    cycle();
    check("t5_count", 64'(count), 64'd2);
    check("t5_iv", 64'(issue_valid), 64'd0);
    drain();

    // plan 6: asynchronous reset mid-cycle
    rob_head = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); disp(i, 1, i + 1, 1, i + 2, 400 + i, 10 + i);
      cycle();
    end
    idle(); fu_ready = 1; cycle();
    check("t6_pre_iv", 64'(issue_valid), 64'd1);
    idle();
    #2;
    reset = 0;
    #1;
    mq.delete();
    exp_iv = 0;
    e_ps1 = 0; e_ps2 = 0; e_pd = 0; e_rob = 0; e_imm = 0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_iv", 64'(issue_valid), 64'd0);
    check_outs();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      idle(); fu_ready = 1; cycle();
    end
    idle(); disp(3, 1, 4, 1, 5, 6, 20); fu_ready = 1; cycle();
    idle(); fu_ready = 1; cycle();
    check("t6_new_rob", 64'(issue_rob), 64'd20);

    // random traffic
    tail = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      minseq = tail;
      rob_head = RW'(tail % 32);
      foreach (mq[i])
        if (mq[i].seq < minseq) begin
          minseq = mq[i].seq;
          rob_head = RW'(mq[i].rob);
        end
      if ($urandom % 3 != 0 && tail - minseq < 24)
        disp($urandom % 16, 1'($urandom % 2),
             $urandom % 16, 1'($urandom % 2),
             $urandom % 128,
             longint'({$urandom, $urandom}),
             tail % 32);
      cdb_valid = NC'($urandom % 4);
      cdb_tag = {PW'($urandom % 16), PW'($urandom % 16)};
      fu_ready = ($urandom % 10) < 7;
      if (mq.size() > 0 && $urandom % 16 == 0) begin
        mispredict = 1;
        mispredict_rob =
          RW'(mq[$urandom % mq.size()].rob);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
